// File: rtl/accel_sample_sequencer.sv
// ADXL345 sequencer: configures the sensor, then periodically reads X/Y/Z through a single-byte SPI master.
// Optional build macro ACCEL_DEVID_CHECK_EN adds a DEVID (reg 0x00) check ahead of the config writes.
module accel_sample_sequencer #(
    parameter int          SAMPLE_PERIOD   = 50000,
    parameter int          STARTUP_CYCLES  = 32768,
    parameter logic [7:0]  BW_RATE_VAL     = 8'h0A,
    parameter logic [7:0]  DATA_FORMAT_VAL = 8'h0B,
    parameter logic [7:0]  POWER_CTL_VAL   = 8'h08
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        spi_start,
    output logic [5:0]  spi_address,
    output logic        spi_read_write,
    output logic        spi_multi_byte,
    output logic [7:0]  spi_data,
    input  logic [7:0]  spi_data_out,
    input  logic        spi_done,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        sample_valid,
    output logic        init_done,
    output logic        busy
`ifdef ACCEL_DEVID_CHECK_EN
    ,
    output logic        devid_error
`endif
);

    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SAMPLE_PERIOD - 1);
    localparam logic [SW-1:0] SMAX = SW'(STARTUP_CYCLES - 1);

    typedef enum logic [3:0] {
        S_STARTUP,
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_WAIT_LOW,
        S_NEXT,
        S_PUBLISH,
        S_PERIOD
`ifdef ACCEL_DEVID_CHECK_EN
        ,
        S_ERROR
`endif
    } state_t;

    typedef enum logic [1:0] {
        PH_DEVID,
        PH_CFG,
        PH_READ
    } phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [2:0]      step_q, step_d;
    logic [SW-1:0]   start_cnt_q, start_cnt_d;
    logic [PW-1:0]   period_cnt_q, period_cnt_d;
    logic            done_q;
    logic            done_rise;

    logic [5:0]      addr_q;
    logic            rw_q;
    logic [7:0]      wdata_q;
    logic [5:0]      cmd_addr;
    logic            cmd_rw;
    logic [7:0]      cmd_wdata;

    logic [7:0]      sh_q [6];
    logic [5:0]      cap_en;
    logic            capture_read;

    logic [15:0]     accel_x_q, accel_y_q, accel_z_q;
    logic            sample_valid_q;
    logic            init_done_q;

`ifdef ACCEL_DEVID_CHECK_EN
    logic            devid_ok_q;
    logic            devid_error_q;
`endif

    assign done_rise = spi_done & ~done_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        step_d       = step_q;
        start_cnt_d  = start_cnt_q;
        period_cnt_d = (period_cnt_q == PMAX) ? period_cnt_q : period_cnt_q + 1'b1;

        case (state_q)
            S_STARTUP: begin
                // done_rise is deliberately ignored here to swallow a transaction left in flight
                if (start_cnt_q == SMAX) begin
                    state_d = S_IDLE;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (enable) begin
                    step_d = 3'd0;
                    if (!init_done_q) begin
`ifdef ACCEL_DEVID_CHECK_EN
                        phase_d = PH_DEVID;
`else
                        phase_d = PH_CFG;
`endif
                        state_d = S_ISSUE;
                    end else begin
                        phase_d = PH_READ;
                        state_d = S_PERIOD;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_rise) begin
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (!spi_done) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                case (phase_q)
                    PH_CFG: begin
                        if (step_q == 3'd2) begin
                            phase_d = PH_READ;
                            step_d  = 3'd0;
                            state_d = S_PERIOD;
                        end else begin
                            step_d  = step_q + 3'd1;
                            state_d = S_ISSUE;
                        end
                    end
                    PH_READ: begin
                        if (step_q == 3'd5) begin
                            state_d = S_PUBLISH;
                        end else begin
                            step_d  = step_q + 3'd1;
                            state_d = S_ISSUE;
                        end
                    end
`ifdef ACCEL_DEVID_CHECK_EN
                    PH_DEVID: begin
                        if (devid_ok_q) begin
                            phase_d = PH_CFG;
                            step_d  = 3'd0;
                            state_d = S_ISSUE;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end
`endif
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_PUBLISH: begin
                phase_d = PH_READ;
                step_d  = 3'd0;
                state_d = S_PERIOD;
            end
            S_PERIOD: begin
                if (period_cnt_q == PMAX) begin
                    if (!enable) begin
                        state_d = S_IDLE;
                    end else begin
                        phase_d = PH_READ;
                        step_d  = 3'd0;
                        state_d = S_ISSUE;
                    end
                end
            end
`ifdef ACCEL_DEVID_CHECK_EN
            S_ERROR: begin
                state_d = S_ERROR;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clearing on entry makes timer==0 coincide with the step-0 start pulse
        if (state_d == S_ISSUE && phase_d == PH_READ && step_d == 3'd0) begin
            period_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Command decode for the transaction about to be issued
    // ------------------------------------------------------------------
    always_comb begin
        cmd_addr  = 6'h00;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'h00;
        case (phase_d)
            PH_DEVID: begin
                cmd_addr = 6'h00;
                cmd_rw   = 1'b1;
            end
            PH_CFG: begin
                case (step_d)
                    3'd0: begin
                        cmd_addr  = 6'h2C;
                        cmd_wdata = BW_RATE_VAL;
                    end
                    3'd1: begin
                        cmd_addr  = 6'h31;
                        cmd_wdata = DATA_FORMAT_VAL;
                    end
                    default: begin
                        cmd_addr  = 6'h2D;
                        cmd_wdata = POWER_CTL_VAL;
                    end
                endcase
            end
            PH_READ: begin
                cmd_addr = 6'h32 + {3'b000, step_d};
                cmd_rw   = 1'b1;
            end
            default: begin
                cmd_addr = 6'h00;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_STARTUP;
            phase_q      <= PH_CFG;
            step_q       <= 3'd0;
            start_cnt_q  <= '0;
            period_cnt_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            step_q       <= step_d;
            start_cnt_q  <= start_cnt_d;
            period_cnt_q <= period_cnt_d;
            done_q       <= spi_done;
        end
    end

    // Command fields stay stable for the whole transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= 6'h00;
            rw_q    <= 1'b0;
            wdata_q <= 8'h00;
        end else if (state_d == S_ISSUE) begin
            addr_q  <= cmd_addr;
            rw_q    <= cmd_rw;
            wdata_q <= cmd_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read-data shadow bytes
    // ------------------------------------------------------------------
    assign capture_read = (state_q == S_WAIT_DONE) && done_rise && (phase_q == PH_READ);

    for (genvar gi = 0; gi < 6; gi++) begin : g_cap_en
        assign cap_en[gi] = capture_read && (step_q == 3'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                sh_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (cap_en[i]) begin
                    sh_q[i] <= spi_data_out;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Published samples and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accel_x_q      <= 16'h0000;
            accel_y_q      <= 16'h0000;
            accel_z_q      <= 16'h0000;
            sample_valid_q <= 1'b0;
            init_done_q    <= 1'b0;
        end else begin
            sample_valid_q <= (state_q == S_PUBLISH);
            if (state_q == S_PUBLISH) begin
                accel_x_q <= {sh_q[1], sh_q[0]};
                accel_y_q <= {sh_q[3], sh_q[2]};
                accel_z_q <= {sh_q[5], sh_q[4]};
            end
            if (state_q == S_NEXT && phase_q == PH_CFG && step_q == 3'd2) begin
                init_done_q <= 1'b1;
            end
        end
    end

`ifdef ACCEL_DEVID_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            devid_ok_q    <= 1'b0;
            devid_error_q <= 1'b0;
        end else begin
            if (state_q == S_WAIT_DONE && done_rise && phase_q == PH_DEVID) begin
                devid_ok_q <= (spi_data_out == 8'hE5);
            end
            if (state_q == S_NEXT && phase_q == PH_DEVID && !devid_ok_q) begin
                devid_error_q <= 1'b1;
            end
        end
    end

    assign devid_error = devid_error_q;
`endif

    assign spi_start      = (state_q == S_ISSUE);
    assign busy           = (state_q == S_ISSUE) || (state_q == S_WAIT_DONE) || (state_q == S_WAIT_LOW);
    assign spi_address    = addr_q;
    assign spi_read_write = rw_q;
    assign spi_multi_byte = 1'b0;
    assign spi_data       = wdata_q;
    assign accel_x        = accel_x_q;
    assign accel_y        = accel_y_q;
    assign accel_z        = accel_z_q;
    assign sample_valid   = sample_valid_q;
    assign init_done      = init_done_q;

endmodule

// File: doc/accel_sample_sequencer.md
Name: accel_sample_sequencer

Overview:
- Upstream controller for the accelerometer SPI master.
- After reset it configures the ADXL345 with three register writes, then periodically reads the six data registers 0x32..0x37, one single-byte transaction per register.
- It assembles signed 16-bit X/Y/Z samples and publishes them to the stabilization logic with a one-cycle valid strobe.
- Drives the master's start/address/read_write/multi_byte/data inputs and consumes its data_out/done outputs.

Parameters:
- SAMPLE_PERIOD, 50000, clk cycles between starts of consecutive read bursts (1 kHz at 50 MHz).
- STARTUP_CYCLES, 32768, post-reset hold before first transaction; must be at least one full master transaction plus the sensor power-up time.
- BW_RATE_VAL, 8'h0A, value written to reg 0x2C.
- DATA_FORMAT_VAL, 8'h0B, value written to reg 0x31.
- POWER_CTL_VAL, 8'h08, value written to reg 0x2D (measure mode).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- spi_start  out  1  one-cycle start pulse to the master.
- spi_address  out  6  register address.
- spi_read_write  out  1  1 = read, 0 = write.
- spi_multi_byte  out  1  tied 0 (single-byte transactions only).
- spi_data  out  8  write data.
- spi_data_out  in  8  read data from the master.
- spi_done  in  1  master done level; may stay high for many clk cycles.
- accel_x, accel_y, accel_z  out  16 each  signed samples, {MSB, LSB}.
- sample_valid  out  1  one-cycle pulse when the axes update.
- init_done  out  1  high once all config writes have completed.
- busy  out  1  high while a transaction is outstanding.

Behaviour:
- Reset values: all outputs 0, except spi_multi_byte, which is constant 0. State = S_STARTUP. Timers, indices and the done_q register are cleared.
- Done handling: done_q registers spi_done each cycle. done_rise = spi_done & ~done_q.
- States:
  - S_STARTUP: count to STARTUP_CYCLES-1, then go to S_IDLE. Any done_rise in this window is ignored, which absorbs a master transaction left in flight by a mid-transaction reset.
  - S_IDLE: wait for enable=1. If init_done=0, select config step 0; otherwise select read step 0 and go to S_PERIOD.
  - S_ISSUE: spi_start=1 for exactly this cycle; busy=1. Go to S_WAIT_DONE.
  - S_WAIT_DONE: wait for done_rise. In the done_rise cycle, a read step captures spi_data_out into shadow byte [step]. Go to S_WAIT_LOW.
  - S_WAIT_LOW: wait for spi_done=0, then go to S_NEXT. No new start is issued while done is still high.
  - S_NEXT:
    - Config steps 0..2 are (0x2C, BW_RATE_VAL), (0x31, DATA_FORMAT_VAL), (0x2D, POWER_CTL_VAL).
    - After step 2: set init_done=1 and go to S_PERIOD.
    - Read steps 0..5 use addresses 0x32+step. After step 5, go to S_PUBLISH; otherwise increment the step and go to S_ISSUE.
  - S_PUBLISH:
    - accel_x = {sh[1],sh[0]}, accel_y = {sh[3],sh[2]}, accel_z = {sh[5],sh[4]}, all loaded in the same cycle.
    - sample_valid = 1 for this cycle only. Go to S_PERIOD.
  - S_PERIOD: wait until the period timer has reached SAMPLE_PERIOD-1. If enable=0, go to S_IDLE; otherwise go to S_ISSUE with read step 0.
- spi_address, spi_read_write and spi_data are loaded on entry to S_ISSUE and held unchanged until S_NEXT.
- Period timer:
  - Cleared on each burst's S_ISSUE of step 0; counts every cycle and saturates at SAMPLE_PERIOD-1.
  - If a burst overruns the period, the next burst starts immediately after S_PERIOD (one cycle).
- Enable deasserted mid-burst: the current burst, including publish, completes; then S_PERIOD → S_IDLE. The master cannot be aborted.
- Enable deasserted during config: config completes, then the block goes to S_IDLE.
- Re-enable after init_done=1: config writes are skipped.
- Accel outputs hold their last values between publishes and while disabled.

Optional Feature:
- Macro: ACCEL_DEVID_CHECK_EN.
- When defined:
  - Adds an output port `devid_error  out  1`.
  - Before config step 0, one read of reg 0x00 is issued.
  - If the read returns 8'hE5, the sequence proceeds to the config writes.
  - Otherwise devid_error=1 (sticky until rst), the FSM enters S_ERROR, and no further starts are issued.
- When not defined: no DEVID read, no devid_error port, no S_ERROR state.

Test Plan:
- Reset, enable=1, SPI slave model → no spi_start before STARTUP_CYCLES; then three writes in order (0x2C,0x0A), (0x31,0x0B), (0x2D,0x08) with read_write=0; init_done rises after the third done.
- Slave returns 0x32..0x37 = 0x10,0x01,0xF0,0xFF,0x00,0x01 → one sample_valid pulse with accel_x=0x0110, accel_y=0xFFF0, accel_z=0x0100.
- Burst start times with a fast master → successive step-0 spi_start pulses exactly SAMPLE_PERIOD cycles apart; slow master so the burst exceeds SAMPLE_PERIOD → next burst issues one cycle after S_PERIOD is entered.
- Hold spi_done high for 2000 cycles per transaction → exactly one capture per transaction and no new spi_start until spi_done has returned to 0.
- Drop enable during read step 3 → remaining reads complete, one sample_valid pulse, then idle. Re-enable → reads resume with no config writes.
- With ACCEL_DEVID_CHECK_EN defined, slave returns 0xE5 → config proceeds. Slave returns 0x00 → devid_error=1 and no further spi_start pulses for 10^6 cycles.
